// File: rtl/bin2bcd_seq_if.sv
// Handshake and result bundle for the sequential binary-to-BCD converter.
// The master issues start/bin; the converter returns busy/done/bcd/ovf.
interface bin2bcd_seq_if #(
  parameter int unsigned WIDTH_bin = 20,
  parameter int unsigned WIDTH_bcd = 24
);
  logic                 start;
  logic [WIDTH_bin-1:0] bin;
  logic                 busy;
  logic                 done;
  logic [WIDTH_bcd-1:0] bcd;
  logic                 ovf;

  modport master (
    output start,
    output bin,
    input  busy,
    input  done,
    input  bcd,
    input  ovf
  );

  modport slave (
    input  start,
    input  bin,
    output busy,
    output done,
    output bcd,
    output ovf
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one adjust+shift per clock.
// Results are held with a sticky overflow flag until the next completion.
module bin2bcd_seq #(
  parameter int unsigned WIDTH_bin = 20,
  parameter int unsigned WIDTH_bcd = 24
) (
  input  logic          clk,
  input  logic          rst,
  bin2bcd_seq_if.slave  io
);
  localparam int unsigned SW   = WIDTH_bcd + WIDTH_bin;
  localparam int unsigned NDIG = WIDTH_bcd / 4;
  localparam int unsigned CW   = (WIDTH_bin > 1) ? $clog2(WIDTH_bin) : 1;
  localparam int unsigned LAST = WIDTH_bin - 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [SW-1:0]        sr_q, sr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 sticky_q, sticky_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [WIDTH_bcd-1:0] bcd_q, bcd_d;
  logic                 ovf_q, ovf_d;

  logic [SW-1:0]        adj;
  logic [SW-1:0]        shifted;
  logic                 shout;
  logic                 last_iter;

  // Add-3 on every BCD digit >= 5; nibble adds wrap and never carry across digits.
  always_comb begin
    adj = sr_q;
    for (int d = 0; d < int'(NDIG); d++) begin
      if (sr_q[WIDTH_bin + 4*d +: 4] >= 4'd5) begin
        adj[WIDTH_bin + 4*d +: 4] = sr_q[WIDTH_bin + 4*d +: 4] + 4'd3;
      end
    end
  end

  assign shifted   = {adj[SW-2:0], 1'b0};
  assign shout     = adj[SW-1];
  assign last_iter = (cnt_q == CW'(LAST));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    bcd_d    = bcd_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (io.start) begin
          sr_d     = {{WIDTH_bcd{1'b0}}, io.bin};
          cnt_d    = '0;
          sticky_d = 1'b0;
          state_d  = RUN;
        end
      end
      RUN: begin
        sr_d     = shifted;
        sticky_d = sticky_q | shout;
        cnt_d    = cnt_q + CW'(1);
        if (last_iter) begin
          // Publish the BCD field of the post-shift register with this iteration's overflow.
          bcd_d   = shifted[SW-1 -: WIDTH_bcd];
          ovf_d   = sticky_q | shout;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q     <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      bcd_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      bcd_q    <= bcd_d;
      ovf_q    <= ovf_d;
    end
  end

  assign io.busy = busy_q;
  assign io.done = done_q;
  assign io.bcd  = bcd_q;
  assign io.ovf  = ovf_q;
endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential binary-to-BCD converter using the shift/add-3 (double-dabble) algorithm, one iteration per clock. It replaces a fully unrolled chain of combinational shift/adjust stages where area matters more than latency. The clock display path uses it to turn packed binary time/count values into BCD digits for the digit-to-glyph lookup. It has a start/busy/done handshake, a registered BCD output and a sticky overflow flag.

## Interface
- WIDTH_bin, 20, binary input width; must be ≥ 2
- WIDTH_bcd, 24, BCD output width; must be a multiple of 4 (WIDTH_bcd/4 digits)
- clk  input  1  system clock; all logic on the rising edge
- rst  input  1  reset; synchronous and active-high
- start  input  1  request a conversion of bin; sampled only when busy=0
- bin  input  WIDTH_bin  unsigned binary value; sampled on the accepting edge only
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse when bcd/ovf update
- bcd  output  WIDTH_bcd  packed BCD result, most significant digit in the top nibble; held until the next completion
- ovf  output  1  high if the last result did not fit in WIDTH_bcd/4 digits; held with bcd

## Operation
- Working register `sr`, WIDTH_bcd+WIDTH_bin bits wide: BCD field on top, binary field below. Iteration counter `cnt`, width clog2(WIDTH_bin).
- FSM states:
  - IDLE: busy=0. If start=1: load sr={0, bin}, cnt=0, clear the internal sticky overflow bit, go to RUN.
  - RUN: busy=1. Perform one iteration per cycle, then cnt++. When cnt==WIDTH_bin-1, that iteration is the last and the FSM goes to IDLE.
- One iteration: first adjust, then shift.
  - Adjust: every 4-bit BCD digit of sr that is ≥5 gets +3, all digits in parallel. Each nibble add is mod 16 and carries nothing into the next digit.
  - Shift: the adjusted sr is shifted left by 1 and a 0 enters at the LSB.
  - The bit shifted out of the sr MSB is ORed into the sticky overflow bit.
- Completion: on the last iteration's edge, bcd is loaded with the BCD field of the new sr and ovf with the new sticky bit (including that iteration's shifted-out bit). done=1 for exactly the following cycle.
- If ovf=1, bcd holds the low WIDTH_bcd/4 digits of a corrupted conversion. Consumers must not display it as valid.
- start while busy=1 is ignored: it is not queued and bin is not resampled.
- bin may change freely after the accepting edge.

## Timing
- Reset (rst=1 at an edge): FSM=IDLE, sr=0, cnt=0, sticky=0, busy=0, done=0, bcd=0, ovf=0.
- Reset mid-conversion aborts it. No done pulse is produced and bcd/ovf become 0.
- Let E0 be the edge where start=1 is sampled in IDLE:
  - busy=1 from after E0 through edge E_W (W=WIDTH_bin).
  - Iterations occur on edges E1..E_W.
  - bcd/ovf update at E_W; done=1 and busy=0 in the cycle after E_W.
- Latency: start to done is W cycles. The earliest next accepted start is at E_W+1, so throughput is one conversion per W+1 cycles.
- start=1 in the same cycle as done=1 is accepted (FSM is in IDLE). The done pulse is not extended.
- bcd/ovf are stable outside the completion edge and are never mid-conversion values.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Reset, then start with bin=0: done exactly 20 cycles after the accepting edge, bcd=24'h000000, ovf=0, busy high for exactly 20 cycles.
- bin=999999 (20'hF423F): bcd=24'h999999, ovf=0. Then bin=123456: bcd=24'h123456, ovf=0.
- bin=1000000 and bin=1048575: ovf=1 in both cases, done still pulses once. A following bin=59 gives bcd=24'h000059, ovf=0 (sticky is cleared per conversion).
- start held high continuously with bin alternating each cycle: conversions complete every 21 cycles. Each result matches the bin value present on its accepting edge. Starts during busy have no effect.
- rst pulsed at iteration 10 of a conversion of bin=654321: no done, bcd=0, ovf=0, busy=0 on the next cycle. A new start then converts correctly.
- Random regression over 10^4 values of bin: bcd equals the decimal digits of bin when bin ≤ 999999, and ovf = (bin > 999999).
